regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised architectural register file for the single-cycle and pipelined datapaths. It provides two combinational read ports with write-to-read bypass and one general write port. The write port does sub-word extraction with sign or zero extension. A dedicated link port writes `pc+4`. A per-register busy scoreboard produces a load-use stall for the pipeline control.

## Interface
Parameters:
- `DATA_W`, default 32. Register width. Must be 32 or 64. `LANES = DATA_W/8`, `LANE_W = log2(LANES)`.
- `ADDR_W`, default 5. Register index width. `NREGS = 2**ADDR_W`.
- `LINK_REG`, default 31. Index written by the link port.
- `ZERO_REG`, default 1. When 1, register 0 reads as 0, ignores writes and is never busy.

Ports:
- `clk` in, 1 bit. Single clock; all state updates on the rising edge.
- `rst` in, 1 bit. Asynchronous, active-high reset.
- `ra_addr`, `rb_addr` in, `ADDR_W` bits each. Read addresses.
- `ra_use`, `rb_use` in, 1 bit each. The current instruction consumes that read operand.
- `ra_data`, `rb_data` out, `DATA_W` bits each. Read data, combinational, with bypass applied.
- `wr_en` in, 1 bit. General write enable.
- `wr_addr` in, `ADDR_W` bits. General write address.
- `wr_data` in, `DATA_W` bits. Raw write data, e.g. a memory word.
- `wr_size` in, 2 bits. 00 selects byte, 01 selects half, 10 or 11 select full width.
- `wr_lane` in, `LANE_W` bits. Little-endian byte offset of the sub-word within `wr_data`.
- `wr_sext` in, 1 bit. 1 sign-extends the sub-word; 0 zero-extends it.
- `link_en` in, 1 bit. Write `link_pc + 4` into `LINK_REG`.
- `link_pc` in, `DATA_W` bits. PC used by the link write.
- `iss_en` in, 1 bit. Issue of a producer instruction; marks `iss_addr` busy.
- `iss_addr` in, `ADDR_W` bits. Destination register of the issued producer.
- `ra_busy`, `rb_busy` out, 1 bit each. The operand's register has a pending writer that is not being written this cycle.
- `stall` out, 1 bit. Equals `(ra_use & ra_busy) | (rb_use & rb_busy)`.
- `busy_cnt` out, `ADDR_W+1` bits, registered. Number of busy registers.

## Operation
- **Write value formation (`wval`):**
  - Byte: take `wr_data[8*wr_lane +: 8]`.
  - Half: take `wr_data[16*wr_lane[LANE_W-1:1] +: 16]`. `wr_lane[0]` is ignored.
  - Full width: take `wr_data` unchanged.
  - Byte and half values are extended to `DATA_W` by sign or zero according to `wr_sext`.
- **Link value:** `lval = link_pc + 4`, computed modulo `2**DATA_W`. Wrap-around is silent.
- **Commit:** on the rising edge, `regs[wr_addr] <= wval` if `wr_en`, and `regs[LINK_REG] <= lval` if `link_en`.
  - If both target `LINK_REG` in the same cycle, the general write wins.
  - When `ZERO_REG=1`, writes to index 0 are dropped.
- **Read:** `ra_data` is selected in priority order:
  1. 0 if `ZERO_REG` is set and `ra_addr==0`.
  2. `wval` if `wr_en` and `wr_addr==ra_addr`.
  3. `lval` if `link_en` and `ra_addr==LINK_REG`.
  4. Otherwise `regs[ra_addr]`.
  - `rb_data` uses the same rules with `rb_addr`.
- **Scoreboard:** `busy[NREGS-1:0]`.
  - Set when `iss_en` (except index 0 when `ZERO_REG=1`).
  - Cleared by a general write to that index, or by a link write to `LINK_REG`.
  - If set and clear hit the same index in the same cycle, set wins (a newer producer is pending).
- **Busy outputs:** `ra_busy = busy[ra_addr] & ~(bypass hit on ra_addr this cycle)`. `rb_busy` is formed the same way.
- **Count:** `busy_cnt` is updated each cycle to the popcount of the next `busy` value.

## Timing
- **Reset:** asserting `rst` clears all `regs`, all `busy` bits and `busy_cnt` to 0, regardless of `clk`. After reset both read ports return 0 and `stall=0`.
- **Reset during a write:** the write is lost and the register stays 0 until the next edge after `rst` deasserts.
- **Latencies:**
  - Read-to-data: 0 cycles (combinational).
  - Write-to-read: 0 cycles via bypass in the write cycle; from the register array on the following cycle.
  - Issue-to-busy: 1 cycle. `iss_en` at edge N makes `ra_busy` visible from N onward.
  - `busy_cnt` lags `busy` by 0 cycles; both update on the same edge.
- **No handshake:** `stall` is advisory. This block never blocks a write or an issue.

## Structure
- A shared package `cpu_pkg` holds:
  - the `wr_size` encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the link offset constant `LINK_OFS = 4`;
  - the default `LINK_REG`.
- One sub-module, `subword_ext`, which is combinational. Inputs are `wr_data`, `wr_size`, `wr_lane` and `wr_sext`; output is `wval`. The same block is reused later by the memory stage.
- The scoreboard and `busy_cnt` stay inside `regfile_bypass`.

## Test plan
- **Reset:** pulse `rst` mid-cycle after writing `regs[5]=32'h1234` → `ra_addr=5` reads 0; `busy_cnt=0`.
- **Sub-word write:** `wr_data=32'h80FF7F01`.
  - `wr_size=byte`, `wr_lane=3`, `wr_sext=1` → `regs[4]=32'hFFFFFF80`.
  - `wr_lane=2`, `wr_sext=0` → `32'h000000FF`.
  - `wr_size=half`, `wr_lane=2`, `wr_sext=1` → `32'hFFFF80FF`.
- **Bypass:** `wr_en`, `wr_addr=7`, full-width `32'hDEADBEEF`, with `rb_addr=7` in the same cycle → `rb_data=32'hDEADBEEF` before the edge. A write to index 0 → `ra_addr=0` still reads 0.
- **Link conflict:** `link_en`, `link_pc=32'h0040_0010` → `regs[31]=32'h0040_0014`. The same edge with `wr_en`, `wr_addr=31`, data `32'h55` → `regs[31]=32'h55`. `link_pc=32'hFFFF_FFFE` → `32'h2`.
- **Scoreboard:** issue r3 → next cycle `ra_addr=3`, `ra_use=1` gives `stall=1` and `busy_cnt=1`. A write to r3 → `stall=0` in that same cycle and `busy_cnt=0` after the edge. Simultaneous issue and write on r3 → r3 remains busy.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: write-size encodings and link-register defaults.
// Imported by the register file and by the sub-word extension block.
package cpu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } wr_size_e;

    localparam int LINK_OFS         = 4;
    localparam int LINK_REG_DEFAULT = 31;

endpackage

// File: rtl/regfile_bypass_if.sv
// Register-file port bundle: two read ports, the general and link write ports,
// and the issue/scoreboard signals.
interface regfile_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANE_W = $clog2(DATA_W / 8)
);
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic              ra_use;
    logic              rb_use;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [1:0]        wr_size;
    logic [LANE_W-1:0] wr_lane;
    logic              wr_sext;
    logic              link_en;
    logic [DATA_W-1:0] link_pc;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              ra_busy;
    logic              rb_busy;
    logic              stall;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output ra_addr, rb_addr, ra_use, rb_use,
        output wr_en, wr_addr, wr_data, wr_size, wr_lane, wr_sext,
        output link_en, link_pc, iss_en, iss_addr,
        input  ra_data, rb_data, ra_busy, rb_busy, stall, busy_cnt
    );

    modport slave (
        input  ra_addr, rb_addr, ra_use, rb_use,
        input  wr_en, wr_addr, wr_data, wr_size, wr_lane, wr_sext,
        input  link_en, link_pc, iss_en, iss_addr,
        output ra_data, rb_data, ra_busy, rb_busy, stall, busy_cnt
    );

endinterface

// File: rtl/subword_ext.sv
// Combinational sub-word extractor: picks a byte, half or full word out of raw
// data and sign- or zero-extends it. Shared with the memory stage.
module subword_ext
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [1:0]        i_wr_size,
    input  logic [LANE_W-1:0] i_wr_lane,
    input  logic              i_wr_sext,
    output logic [DATA_W-1:0] o_wval
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane-to-bit offsets built by concatenation; a half ignores lane bit 0.
    assign w_byte = i_wr_data[{i_wr_lane, 3'b000} +: 8];
    assign w_half = i_wr_data[{i_wr_lane[LANE_W-1:1], 4'b0000} +: 16];

    // NOTE: every branch assigns o_wval, so no latch is inferred even though
    // the 2'b11 encoding has no named case item.
    always_comb begin
        case (i_wr_size)
            SZ_BYTE: o_wval = {{(DATA_W - 8){i_wr_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_wval = {{(DATA_W - 16){i_wr_sext & w_half[15]}}, w_half};
            default: o_wval = i_wr_data;
        endcase
    end

endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file with write-to-read bypass, a pc+4 link port and
// a per-register busy scoreboard that raises a load-use stall.
module regfile_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = LINK_REG_DEFAULT,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    regfile_bypass_if.slave rf
);

    localparam int                NREGS    = 2 ** ADDR_W;
    localparam int                LANE_W   = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic [DATA_W-1:0] w_wval;
    logic [DATA_W-1:0] w_lval;
    logic              w_wr_ok;
    logic              w_link_ok;
    logic              w_ra_wr_hit;
    logic              w_ra_lk_hit;
    logic              w_rb_wr_hit;
    logic              w_rb_lk_hit;
    logic [NREGS-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;

    subword_ext #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_subword_ext (
        .i_wr_data (rf.wr_data),
        .i_wr_size (rf.wr_size),
        .i_wr_lane (rf.wr_lane),
        .i_wr_sext (rf.wr_sext),
        .o_wval    (w_wval)
    );

    assign w_lval    = rf.link_pc + DATA_W'(LINK_OFS);
    assign w_wr_ok   = rf.wr_en   & ~(ZERO_REG & (rf.wr_addr == '0));
    assign w_link_ok = rf.link_en & ~(ZERO_REG & (LINK_IDX == '0));

    assign w_ra_wr_hit = rf.wr_en   & (rf.wr_addr == rf.ra_addr);
    assign w_ra_lk_hit = rf.link_en & (rf.ra_addr == LINK_IDX);
    assign w_rb_wr_hit = rf.wr_en   & (rf.wr_addr == rf.rb_addr);
    assign w_rb_lk_hit = rf.link_en & (rf.rb_addr == LINK_IDX);

    always_comb begin
        if (ZERO_REG && rf.ra_addr == '0) rf.ra_data = '0;
        else if (w_ra_wr_hit)             rf.ra_data = w_wval;
        else if (w_ra_lk_hit)             rf.ra_data = w_lval;
        else                              rf.ra_data = r_regs[rf.ra_addr];
    end

    always_comb begin
        if (ZERO_REG && rf.rb_addr == '0) rf.rb_data = '0;
        else if (w_rb_wr_hit)             rf.rb_data = w_wval;
        else if (w_rb_lk_hit)             rf.rb_data = w_lval;
        else                              rf.rb_data = r_regs[rf.rb_addr];
    end

    // A register being written this cycle is already satisfied by the bypass.
    assign rf.ra_busy  = r_busy[rf.ra_addr] & ~(w_ra_wr_hit | w_ra_lk_hit);
    assign rf.rb_busy  = r_busy[rf.rb_addr] & ~(w_rb_wr_hit | w_rb_lk_hit);
    assign rf.stall    = (rf.ra_use & rf.ra_busy) | (rf.rb_use & rf.rb_busy);
    assign rf.busy_cnt = r_busy_cnt;

    // NOTE: blocking assignments inside always_comb so later statements see
    // earlier updates; the issue set comes last so a new producer wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (rf.wr_en)   w_busy_nxt[rf.wr_addr]  = 1'b0;
        if (rf.link_en) w_busy_nxt[LINK_IDX]    = 1'b0;
        if (rf.iss_en)  w_busy_nxt[rf.iss_addr] = 1'b1;
        if (ZERO_REG)   w_busy_nxt[0]           = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + (ADDR_W + 1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    // NOTE: the array is flops, not RAM, because every register must read 0
    // straight after reset; the general write is placed after the link write
    // so the later non-blocking update wins on a LINK_REG collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_link_ok) r_regs[LINK_IDX]   <= w_lval;
            if (w_wr_ok)   r_regs[rf.wr_addr] <= w_wval;
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_regfile_bypass;
    import cpu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [1:0]  SW_SIZE [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    localparam logic [1:0]  SW_LANE [4] = '{2'd3, 2'd2, 2'd2, 2'd1};
    localparam logic        SW_SEXT [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] SW_EXP  [4] = '{32'hFFFFFF80, 32'h000000FF,
                                            32'hFFFF80FF, 32'h00007F01};

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) rf ();

    regfile_bypass #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .LINK_REG (31),
        .ZERO_REG (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_wval();
        logic [31:0] v;
        case (rf.wr_size)
            2'b00: begin
                v = (rf.wr_data >> (8 * rf.wr_lane)) & 32'hFF;
                if (rf.wr_sext && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (rf.wr_data >> (16 * (rf.wr_lane / 2))) & 32'hFFFF;
                if (rf.wr_sext && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rf.wr_data;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (rf.wr_en && rf.wr_addr == a) return m_wval();
        if (rf.link_en && a == 5'd31) return rf.link_pc + 32'd4;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (rf.wr_en && rf.wr_addr == a) return 1'b0;
        if (rf.link_en && a == 5'd31) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [5:0] m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
        return 6'(c);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_commit();
        logic [31:0] wv;
        wv = m_wval();
        if (rf.link_en) m_regs[31] = rf.link_pc + 32'd4;
        if (rf.wr_en && rf.wr_addr != 5'd0) m_regs[rf.wr_addr] = wv;
        if (rf.wr_en) m_busy[rf.wr_addr] = 1'b0;
        if (rf.link_en) m_busy[31] = 1'b0;
        if (rf.iss_en && rf.iss_addr != 5'd0) m_busy[rf.iss_addr] = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        rf.ra_addr = '0; rf.rb_addr = '0; rf.ra_use = 1'b0; rf.rb_use = 1'b0;
        rf.wr_en = 1'b0; rf.wr_addr = '0; rf.wr_data = '0; rf.wr_size = SZ_WORD;
        rf.wr_lane = '0; rf.wr_sext = 1'b0; rf.link_en = 1'b0; rf.link_pc = '0;
        rf.iss_en = 1'b0; rf.iss_addr = '0;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d);
        rf.wr_en = 1'b1; rf.wr_addr = a; rf.wr_data = d; rf.wr_size = SZ_WORD;
    endtask

    // Commit the current inputs to the model, cross one rising edge, park on the falling edge.
    task automatic tick();
        m_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'd31;
        return 5'($urandom_range(1, 6));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rf.ra_addr = 5'd5; rf.rb_addr = 5'd31; rf.ra_use = 1'b1; rf.rb_use = 1'b1;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h0) begin n_err++; $display("FAIL reset_ra got=%h exp=0", rf.ra_data); end
        n_cmp++; if (rf.rb_data !== 32'h0) begin n_err++; $display("FAIL reset_rb got=%h exp=0", rf.rb_data); end
        n_cmp++; if (rf.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", rf.stall); end
        n_cmp++; if (rf.busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", rf.busy_cnt); end

        idle();
        write_word(5'd5, 32'h1234);
        rf.iss_en = 1'b1; rf.iss_addr = 5'd3;
        tick();
        idle();
        rf.ra_addr = 5'd5;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h1234) begin n_err++; $display("FAIL pre_rst_r5 got=%h exp=00001234", rf.ra_data); end
        n_cmp++; if (rf.busy_cnt !== 6'd1) begin n_err++; $display("FAIL pre_rst_cnt got=%0d exp=1", rf.busy_cnt); end

        // Asynchronous reset mid-cycle while a write to r5 is still pending.
        write_word(5'd5, 32'hAAAA_0000);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rf.busy_cnt !== 6'd0) begin n_err++; $display("FAIL async_rst_cnt got=%0d exp=0", rf.busy_cnt); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        idle();
        rf.ra_addr = 5'd5; rf.ra_use = 1'b1; rf.rb_addr = 5'd3; rf.rb_use = 1'b1;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h0) begin n_err++; $display("FAIL post_rst_r5 got=%h exp=0", rf.ra_data); end
        n_cmp++; if (rf.stall !== 1'b0) begin n_err++; $display("FAIL post_rst_stall got=%b exp=0", rf.stall); end
    endtask

    task automatic test_subword();
        for (int i = 0; i < 4; i++) begin
            idle();
            rf.wr_en = 1'b1; rf.wr_addr = 5'd4; rf.wr_data = 32'h80FF7F01;
            rf.wr_size = SW_SIZE[i]; rf.wr_lane = SW_LANE[i]; rf.wr_sext = SW_SEXT[i];
            rf.rb_addr = 5'd4;
            #1;
            n_cmp++; if (rf.rb_data !== SW_EXP[i]) begin n_err++; $display("FAIL subword_bypass[%0d] got=%h exp=%h", i, rf.rb_data, SW_EXP[i]); end
            tick();
            idle();
            rf.ra_addr = 5'd4;
            #1;
            n_cmp++; if (rf.ra_data !== SW_EXP[i]) begin n_err++; $display("FAIL subword_reg[%0d] got=%h exp=%h", i, rf.ra_data, SW_EXP[i]); end
        end
    endtask

    task automatic test_bypass();
        idle();
        write_word(5'd7, 32'hDEADBEEF);
        rf.rb_addr = 5'd7;
        #1;
        n_cmp++; if (rf.rb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_rb got=%h exp=deadbeef", rf.rb_data); end
        tick();
        idle();
        rf.rb_addr = 5'd7;
        #1;
        n_cmp++; if (rf.rb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL array_rb got=%h exp=deadbeef", rf.rb_data); end

        write_word(5'd0, 32'h1234_5678);
        rf.ra_addr = 5'd0;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h0) begin n_err++; $display("FAIL zero_bypass got=%h exp=0", rf.ra_data); end
        tick();
        idle();
        #1;
        n_cmp++; if (rf.ra_data !== 32'h0) begin n_err++; $display("FAIL zero_reg got=%h exp=0", rf.ra_data); end
    endtask

    task automatic test_link();
        idle();
        rf.link_en = 1'b1; rf.link_pc = 32'h0040_0010; rf.ra_addr = 5'd31;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h0040_0014) begin n_err++; $display("FAIL link_bypass got=%h exp=00400014", rf.ra_data); end
        tick();
        idle();
        rf.ra_addr = 5'd31;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h0040_0014) begin n_err++; $display("FAIL link_reg got=%h exp=00400014", rf.ra_data); end

        rf.link_en = 1'b1; rf.link_pc = 32'h0000_1000;
        write_word(5'd31, 32'h55);
        #1;
        n_cmp++; if (rf.ra_data !== 32'h55) begin n_err++; $display("FAIL link_conflict_bypass got=%h exp=00000055", rf.ra_data); end
        tick();
        idle();
        rf.ra_addr = 5'd31;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h55) begin n_err++; $display("FAIL link_conflict_reg got=%h exp=00000055", rf.ra_data); end

        rf.link_en = 1'b1; rf.link_pc = 32'hFFFF_FFFE;
        tick();
        idle();
        rf.ra_addr = 5'd31;
        #1;
        n_cmp++; if (rf.ra_data !== 32'h2) begin n_err++; $display("FAIL link_wrap got=%h exp=00000002", rf.ra_data); end
    endtask

    task automatic test_scoreboard();
        idle();
        rf.iss_en = 1'b1; rf.iss_addr = 5'd3;
        tick();
        idle();
        rf.ra_addr = 5'd3; rf.ra_use = 1'b1;
        #1;
        n_cmp++; if (rf.stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_ra got=%b exp=1", rf.stall); end
        n_cmp++; if (rf.busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_cnt_issue got=%0d exp=1", rf.busy_cnt); end
        rf.ra_use = 1'b0; rf.rb_addr = 5'd3; rf.rb_use = 1'b1;
        #1;
        n_cmp++; if (rf.stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_rb got=%b exp=1", rf.stall); end

        write_word(5'd3, 32'h9);
        #1;
        n_cmp++; if (rf.stall !== 1'b0) begin n_err++; $display("FAIL sb_write_unstall got=%b exp=0", rf.stall); end
        tick();
        idle();
        #1;
        n_cmp++; if (rf.busy_cnt !== 6'd0) begin n_err++; $display("FAIL sb_cnt_cleared got=%0d exp=0", rf.busy_cnt); end

        write_word(5'd3, 32'hA);
        rf.iss_en = 1'b1; rf.iss_addr = 5'd3;
        tick();
        idle();
        rf.ra_addr = 5'd3; rf.ra_use = 1'b1;
        #1;
        n_cmp++; if (rf.ra_busy !== 1'b1) begin n_err++; $display("FAIL sb_set_wins got=%b exp=1", rf.ra_busy); end
        n_cmp++; if (rf.busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_set_wins_cnt got=%0d exp=1", rf.busy_cnt); end

        idle();
        rf.iss_en = 1'b1; rf.iss_addr = 5'd31;
        tick();
        idle();
        rf.link_en = 1'b1; rf.rb_addr = 5'd31; rf.rb_use = 1'b1;
        #1;
        n_cmp++; if (rf.rb_busy !== 1'b0) begin n_err++; $display("FAIL sb_link_unbusy got=%b exp=0", rf.rb_busy); end
        n_cmp++; if (rf.busy_cnt !== 6'd2) begin n_err++; $display("FAIL sb_cnt_two got=%0d exp=2", rf.busy_cnt); end
        tick();
        idle();
        #1;
        n_cmp++; if (rf.busy_cnt !== 6'd1) begin n_err++; $display("FAIL sb_link_cleared got=%0d exp=1", rf.busy_cnt); end

        write_word(5'd3, 32'hB);
        rf.iss_en = 1'b1; rf.iss_addr = 5'd0;
        tick();
        idle();
        #1;
        n_cmp++; if (rf.busy_cnt !== 6'd0) begin n_err++; $display("FAIL sb_zero_never_busy got=%0d exp=0", rf.busy_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] e_ra, e_rb;
        logic        e_rab, e_rbb, e_st;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rf.wr_en    = ($urandom_range(0, 99) < 50);
            rf.wr_addr  = pick_addr();
            rf.wr_data  = $urandom;
            rf.wr_size  = 2'($urandom_range(0, 3));
            rf.wr_lane  = 2'($urandom_range(0, 3));
            rf.wr_sext  = 1'($urandom_range(0, 1));
            rf.link_en  = ($urandom_range(0, 99) < 20);
            rf.link_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            rf.iss_en   = ($urandom_range(0, 99) < 40);
            rf.iss_addr = pick_addr();
            rf.ra_addr  = pick_addr();
            rf.rb_addr  = ($urandom_range(0, 3) == 0) ? rf.wr_addr : pick_addr();
            rf.ra_use   = 1'($urandom_range(0, 1));
            rf.rb_use   = 1'($urandom_range(0, 1));
            #1;
            e_ra  = exp_rd(rf.ra_addr);
            e_rb  = exp_rd(rf.rb_addr);
            e_rab = exp_busy(rf.ra_addr);
            e_rbb = exp_busy(rf.rb_addr);
            e_st  = (rf.ra_use & e_rab) | (rf.rb_use & e_rbb);
            n_cmp++; if (rf.ra_data !== e_ra) begin n_err++; $display("FAIL rand_ra_data cyc=%0d got=%h exp=%h", cyc, rf.ra_data, e_ra); end
            n_cmp++; if (rf.rb_data !== e_rb) begin n_err++; $display("FAIL rand_rb_data cyc=%0d got=%h exp=%h", cyc, rf.rb_data, e_rb); end
            n_cmp++; if (rf.ra_busy !== e_rab) begin n_err++; $display("FAIL rand_ra_busy cyc=%0d got=%b exp=%b", cyc, rf.ra_busy, e_rab); end
            n_cmp++; if (rf.rb_busy !== e_rbb) begin n_err++; $display("FAIL rand_rb_busy cyc=%0d got=%b exp=%b", cyc, rf.rb_busy, e_rbb); end
            n_cmp++; if (rf.stall !== e_st) begin n_err++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, rf.stall, e_st); end
            n_cmp++; if (rf.busy_cnt !== m_cnt()) begin n_err++; $display("FAIL rand_busy_cnt cyc=%0d got=%0d exp=%0d", cyc, rf.busy_cnt, m_cnt()); end
            tick();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        m_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_subword();
        test_bypass();
        test_link();
        test_scoreboard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
